// File: rtl/countdown_mmss.sv
// BCD MM:SS countdown timer: load/start/pause control, one-second decrement per tick, stops at 00:00.
// All outputs registered, one cycle after the causing edge; no backpressure (tick is a plain enable).
module countdown_mmss #(
  parameter int MIN1_MAX = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] load_min1,
  input  logic [3:0] load_min0,
  input  logic [3:0] load_sec1,
  input  logic [3:0] load_sec0,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic       running,
  output logic       done,
  output logic       expired,
  output logic       borrow_min
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] MIN1_D = MIN1_MAX[3:0];

  logic [1:0] state;

  logic [3:0] c_min1, c_min0, c_sec1, c_sec0;
  logic [3:0] d_min1, d_min0, d_sec1, d_sec0;
  logic       b_sec0, b_sec1, b_min0;
  logic       cnt_zero, dec_zero;

  always_comb begin
    c_min1 = (load_min1 > MIN1_D) ? MIN1_D : load_min1;
    c_min0 = (load_min0 > 4'd9)   ? 4'd9   : load_min0;
    c_sec1 = (load_sec1 > 4'd5)   ? 4'd5   : load_sec1;
    c_sec0 = (load_sec0 > 4'd9)   ? 4'd9   : load_sec0;
  end

  // Borrow ripples sec0 -> sec1 -> min0 -> min1; min1 cannot underflow since 00:00 never decrements.
  always_comb begin
    b_sec0 = (sec0 == 4'd0);
    b_sec1 = b_sec0 && (sec1 == 4'd0);
    b_min0 = b_sec1 && (min0 == 4'd0);
    d_sec0 = b_sec0 ? 4'd9 : sec0 - 4'd1;
    d_sec1 = b_sec0 ? ((sec1 == 4'd0) ? 4'd5 : sec1 - 4'd1) : sec1;
    d_min0 = b_sec1 ? ((min0 == 4'd0) ? 4'd9 : min0 - 4'd1) : min0;
    d_min1 = b_min0 ? min1 - 4'd1 : min1;
    cnt_zero = (min1 == 4'd0) && (min0 == 4'd0) && (sec1 == 4'd0) && (sec0 == 4'd0);
    dec_zero = (d_min1 == 4'd0) && (d_min0 == 4'd0) && (d_sec1 == 4'd0) && (d_sec0 == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      min1       <= 4'd0;
      min0       <= 4'd0;
      sec1       <= 4'd0;
      sec0       <= 4'd0;
      expired    <= 1'b0;
      borrow_min <= 1'b0;
    end else begin
      expired    <= 1'b0;
      borrow_min <= 1'b0;
      if (load) begin
        state <= S_IDLE;
        min1  <= c_min1;
        min0  <= c_min0;
        sec1  <= c_sec1;
        sec0  <= c_sec0;
      end else begin
        case (state)
          S_IDLE, S_PAUSE: begin
            if (start && !cnt_zero) state <= S_RUN;
          end
          S_RUN: begin
            if (pause) begin
              state <= S_PAUSE;
            end else if (tick) begin
              min1       <= d_min1;
              min0       <= d_min0;
              sec1       <= d_sec1;
              sec0       <= d_sec0;
              borrow_min <= b_sec1;
              if (dec_zero) begin
                state   <= S_DONE;
                expired <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign running = (state == S_RUN);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_countdown_mmss.sv
// Bench for countdown_mmss: directed scenarios plus random stimulus against a seconds-count model.
module tb_countdown_mmss;

  logic       clk = 1'b0;
  logic       rst = 1'b0, tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [3:0] load_min1 = 4'd0, load_min0 = 4'd0, load_sec1 = 4'd0, load_sec0 = 4'd0;
  logic [3:0] min1, min0, sec1, sec0;
  logic       running, done, expired, borrow_min;

  countdown_mmss #(.MIN1_MAX(5)) dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load),
    .load_min1(load_min1), .load_min0(load_min0), .load_sec1(load_sec1), .load_sec0(load_sec0),
    .start(start), .pause(pause),
    .min1(min1), .min0(min0), .sec1(sec1), .sec0(sec0),
    .running(running), .done(done), .expired(expired), .borrow_min(borrow_min)
  );

  always #5 clk = ~clk;

  // {digits, running, done, expired, borrow_min}
  logic [19:0] obs;
  assign obs = {min1, min0, sec1, sec0, running, done, expired, borrow_min};

  int n_checks = 0;
  int n_pass   = 0;

  // Model: remaining time in whole seconds plus a state name.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_tot = 0;
  int m_st  = M_IDLE;
  bit m_exp = 0;
  bit m_bor = 0;

  function automatic int clampd(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [19:0] exp_vec();
    logic [15:0] d;
    d = {4'(m_tot / 600), 4'((m_tot / 60) % 10), 4'((m_tot % 60) / 10), 4'(m_tot % 10)};
    return {d, (m_st == M_RUN), (m_st == M_DONE), m_exp, m_bor};
  endfunction

  task automatic model_step(input bit r, input bit l, input int a, input int b, input int c,
                            input int d, input bit st, input bit pa, input bit tk);
    m_exp = 0;
    m_bor = 0;
    if (r) begin
      m_tot = 0;
      m_st  = M_IDLE;
    end else if (l) begin
      m_tot = (clampd(a, 5) * 10 + clampd(b, 9)) * 60 + clampd(c, 5) * 10 + clampd(d, 9);
      m_st  = M_IDLE;
    end else if (m_st == M_IDLE || m_st == M_PAUSE) begin
      if (st && m_tot != 0) m_st = M_RUN;
    end else if (m_st == M_RUN) begin
      if (pa) m_st = M_PAUSE;
      else if (tk) begin
        if (m_tot % 60 == 0) m_bor = 1;
        m_tot = m_tot - 1;
        if (m_tot == 0) begin
          m_st  = M_DONE;
          m_exp = 1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input bit r, input bit l, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d, input bit st, input bit pa,
                      input bit tk);
    rst = r; load = l; load_min1 = a; load_min0 = b; load_sec1 = c; load_sec0 = d;
    start = st; pause = pa; tick = tk;
    @(posedge clk);
    #1;
    model_step(r, l, int'(a), int'(b), int'(c), int'(d), st, pa, tk);
    rst = 0; load = 0; start = 0; pause = 0; tick = 0;
  endtask

  task automatic do_rst();                  step(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_start();                step(0, 0, 0, 0, 0, 0, 1, 0, 0); endtask
  task automatic do_tick();                 step(0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic do_nop();                  step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_load(input logic [3:0] a, b, c, d, input bit tk);
    step(0, 1, a, b, c, d, 0, 0, tk);
  endtask

  task automatic test_reset();
    do_rst();
    n_checks++;
    if (obs !== 20'h0) $display("FAIL reset_state: got %h want %h", obs, 20'h0);
    else n_pass++;
  endtask

  task automatic test_borrow();
    do_rst();
    do_load(0, 1, 0, 0, 0);
    do_start();
    do_tick();
    n_checks++;
    if (obs !== {16'h0059, 4'b1001}) $display("FAIL borrow_wrap: got %h want %h", obs, {16'h0059, 4'b1001});
    else n_pass++;
    do_nop();
    n_checks++;
    if (obs !== {16'h0059, 4'b1000}) $display("FAIL borrow_one_cycle: got %h want %h", obs, {16'h0059, 4'b1000});
    else n_pass++;
  endtask

  task automatic test_expiry();
    do_load(0, 0, 0, 2, 0);
    do_start();
    do_tick();
    n_checks++;
    if (obs !== {16'h0001, 4'b1000}) $display("FAIL expiry_0001: got %h want %h", obs, {16'h0001, 4'b1000});
    else n_pass++;
    do_tick();
    n_checks++;
    if (obs !== {16'h0000, 4'b0110}) $display("FAIL expiry_pulse: got %h want %h", obs, {16'h0000, 4'b0110});
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      do_tick();
      n_checks++;
      if (obs !== {16'h0000, 4'b0100}) $display("FAIL expiry_hold_%0d: got %h want %h", i, obs, {16'h0000, 4'b0100});
      else n_pass++;
    end
  endtask

  task automatic test_clamp();
    do_load(4'hF, 4'hA, 4'h7, 4'hC, 0);
    n_checks++;
    if (obs !== {16'h5959, 4'b0000}) $display("FAIL clamp_load: got %h want %h", obs, {16'h5959, 4'b0000});
    else n_pass++;
    do_start();
    do_tick();
    n_checks++;
    if (obs !== {16'h5958, 4'b1000}) $display("FAIL clamp_tick: got %h want %h", obs, {16'h5958, 4'b1000});
    else n_pass++;
  endtask

  task automatic test_pause();
    do_load(1, 0, 0, 0, 0);
    do_start();
    for (int i = 0; i < 3; i++) do_tick();
    n_checks++;
    if (obs !== {16'h0957, 4'b1000}) $display("FAIL pause_3ticks: got %h want %h", obs, {16'h0957, 4'b1000});
    else n_pass++;
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    n_checks++;
    if (obs !== {16'h0957, 4'b0000}) $display("FAIL pause_wins: got %h want %h", obs, {16'h0957, 4'b0000});
    else n_pass++;
    do_tick();
    n_checks++;
    if (obs !== {16'h0957, 4'b0000}) $display("FAIL paused_tick: got %h want %h", obs, {16'h0957, 4'b0000});
    else n_pass++;
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    n_checks++;
    if (obs !== {16'h0957, 4'b1000}) $display("FAIL resume_tick_ignored: got %h want %h", obs, {16'h0957, 4'b1000});
    else n_pass++;
    do_tick();
    n_checks++;
    if (obs !== {16'h0956, 4'b1000}) $display("FAIL resume_count: got %h want %h", obs, {16'h0956, 4'b1000});
    else n_pass++;
  endtask

  task automatic test_zero_load();
    do_load(0, 0, 0, 0, 0);
    do_start();
    n_checks++;
    if (obs !== 20'h0) $display("FAIL zero_start: got %h want %h", obs, 20'h0);
    else n_pass++;
    do_load(0, 3, 1, 0, 0);
    do_start();
    do_load(0, 0, 3, 0, 1);
    n_checks++;
    if (obs !== {16'h0030, 4'b0000}) $display("FAIL load_override: got %h want %h", obs, {16'h0030, 4'b0000});
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    do_load(1, 2, 3, 4, 0);
    do_start();
    n_checks++;
    if (obs !== {16'h1234, 4'b1000}) $display("FAIL run_1234: got %h want %h", obs, {16'h1234, 4'b1000});
    else n_pass++;
    step(1, 0, 0, 0, 0, 0, 1, 0, 1);
    n_checks++;
    if (obs !== 20'h0) $display("FAIL rst_mid_run: got %h want %h", obs, 20'h0);
    else n_pass++;
    do_tick();
    n_checks++;
    if (obs !== 20'h0) $display("FAIL rst_then_tick: got %h want %h", obs, 20'h0);
    else n_pass++;
  endtask

  task automatic test_random();
    bit r, l, st, pa, tk;
    logic [3:0] a, b, c, d;
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      l  = ($urandom_range(0, 29) == 0);
      st = ($urandom_range(0, 5) == 0);
      pa = ($urandom_range(0, 19) == 0);
      tk = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 0) begin
        a = 0; b = 0; c = 4'($urandom_range(0, 2)); d = 4'($urandom_range(0, 15));
      end else begin
        a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
        c = 4'($urandom_range(0, 15)); d = 4'($urandom_range(0, 15));
      end
      step(r, l, a, b, c, d, st, pa, tk);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL random_%0d: got %h want %h", i, obs, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_borrow();
    test_expiry();
    test_clamp();
    test_pause();
    test_zero_load();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
